// File: rtl/uart_reception.sv
// 8N1 UART receiver with mid-bit sampling, framing-error and false-start detection.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_reception #(
    parameter int unsigned baud_rate_p   = 5208,
    parameter int unsigned half_bit_p    = 2604,
    parameter int unsigned data_length_p = 8
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    input  logic                     Rx_i,
    output logic [data_length_p-1:0] Data_o,
    output logic                     Data_valid_o,
    output logic                     Frame_error_o,
`ifdef UART_RX_PARITY_EN
    output logic                     Parity_error_o,
`endif
    output logic                     Busy_o
);

    localparam int unsigned BW       = $clog2(data_length_p + 1);
    localparam logic [15:0] BIT_LIM  = 16'(baud_rate_p - 1);
    localparam logic [15:0] HALF_LIM = 16'(half_bit_p - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(data_length_p - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                   state_q, state_n;
    logic                     sync1_q, rx_s;
    logic [15:0]              tick_q, tick_n;
    logic [BW-1:0]            bit_q, bit_n;
    logic [data_length_p-1:0] shift_q, shift_n;
    logic [data_length_p-1:0] data_n;
    logic                     valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                     par_q, par_n, perr_n;
`endif

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            sync1_q       <= 1'b1;
            rx_s          <= 1'b1;
            state_q       <= S_IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            Data_o        <= '0;
            Data_valid_o  <= 1'b0;
            Frame_error_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q          <= 1'b0;
            Parity_error_o <= 1'b0;
`endif
        end else begin
            sync1_q       <= Rx_i;
            rx_s          <= sync1_q;
            state_q       <= state_n;
            tick_q        <= tick_n;
            bit_q         <= bit_n;
            shift_q       <= shift_n;
            Data_o        <= data_n;
            Data_valid_o  <= valid_n;
            Frame_error_o <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q          <= par_n;
            Parity_error_o <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state_q;
        tick_n  = tick_q + 16'd1;
        bit_n   = bit_q;
        shift_n = shift_q;
        data_n  = Data_o;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_q;
        perr_n  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                tick_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (tick_q == HALF_LIM) begin
                    tick_n = '0;
                    bit_n  = '0;
`ifdef UART_RX_PARITY_EN
                    par_n  = 1'b0;
`endif
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_q == BIT_LIM) begin
                    tick_n  = '0;
                    shift_n = {rx_s, shift_q[data_length_p-1:1]};
                    bit_n   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_n   = par_q ^ rx_s;
                    if (bit_q == LAST_BIT) state_n = S_PARITY;
`else
                    if (bit_q == LAST_BIT) state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_q == BIT_LIM) begin
                    tick_n  = '0;
                    par_n   = par_q ^ rx_s;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_q == BIT_LIM) begin
                    tick_n = '0;
                    if (rx_s) begin
                        // Leaving at the stop-bit midpoint lets a following start bit be caught.
                        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_q) begin
                            perr_n = 1'b1;
                        end else begin
                            data_n  = shift_q;
                            valid_n = 1'b1;
                        end
`else
                        data_n  = shift_q;
                        valid_n = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                tick_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                tick_n  = '0;
                bit_n   = '0;
                shift_n = '0;
                data_n  = '0;
`ifdef UART_RX_PARITY_EN
                par_n   = 1'b0;
`endif
            end
        endcase
    end

    assign Busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reception.sv
// Directed bench for uart_reception at 16 clocks/bit with a byte scoreboard.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_reception;

    localparam int unsigned BAUD = 16;
    localparam int unsigned HALF = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned LAT = 2 + HALF + 10 * BAUD;
`else
    localparam int unsigned LAT = 2 + HALF + 9 * BAUD;
`endif

    logic       Clk_i, Reset_i, Rx_i;
    logic [7:0] Data_o;
    logic       Data_valid_o, Frame_error_o, Busy_o;
`ifdef UART_RX_PARITY_EN
    logic       Parity_error_o;
`endif

    uart_reception #(
        .baud_rate_p  (BAUD),
        .half_bit_p   (HALF),
        .data_length_p(8)
    ) dut (
        .Clk_i        (Clk_i),
        .Reset_i      (Reset_i),
        .Rx_i         (Rx_i),
        .Data_o       (Data_o),
        .Data_valid_o (Data_valid_o),
        .Frame_error_o(Frame_error_o),
`ifdef UART_RX_PARITY_EN
        .Parity_error_o(Parity_error_o),
`endif
        .Busy_o       (Busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int last_valid_cyc = 0;
    int t_start = 0;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] exp_q[$];

    initial begin
        Clk_i = 1'b0;
        forever #5 Clk_i = ~Clk_i;
    end

    always @(posedge Clk_i) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge Clk_i) begin
        if (Reset_i) begin
            if (Data_valid_o) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                check("valid_width", {31'd0, prev_valid}, 32'd0);
                check("valid_ferr_excl", {31'd0, Frame_error_o}, 32'd0);
                check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("sb_data", {24'd0, Data_o}, {24'd0, exp_q.pop_front()});
            end
            if (Frame_error_o) begin
                ferr_cnt++;
                check("ferr_width", {31'd0, prev_ferr}, 32'd0);
            end
`ifdef UART_RX_PARITY_EN
            if (Parity_error_o) perr_cnt++;
`endif
        end
        prev_valid = Data_valid_o;
        prev_ferr  = Frame_error_o;
    end

    // Drives one frame starting at a falling edge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        Rx_i = 1'b0;
        t_start = cyc + 1;
        repeat (BAUD) @(negedge Clk_i);
        for (int i = 0; i < 8; i++) begin
            Rx_i = d[i];
            repeat (BAUD) @(negedge Clk_i);
        end
`ifdef UART_RX_PARITY_EN
        Rx_i = (^d) ^ par_flip;
        repeat (BAUD) @(negedge Clk_i);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        Rx_i = stop_b;
        repeat (BAUD) @(negedge Clk_i);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge Clk_i);
        check(tag, exp_q.size(), 0);
    endtask

    int v0, f0, p0, busy_seen, t_drop;

    initial begin
        Reset_i = 1'b0;
        Rx_i    = 1'b1;
        @(negedge Clk_i);
        for (int i = 0; i < 8; i++) begin
            Rx_i = ~Rx_i;
            @(negedge Clk_i);
        end
        check("rst_data", {24'd0, Data_o}, 0);
        check("rst_valid", {31'd0, Data_valid_o}, 0);
        check("rst_ferr", {31'd0, Frame_error_o}, 0);
        check("rst_busy", {31'd0, Busy_o}, 0);
        Rx_i = 1'b1;
        @(negedge Clk_i);
        Reset_i = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk_i);
            if (Busy_o) busy_seen++;
        end
        check("idle_busy", busy_seen, 0);

        // Single frame with latency
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        drain("a5_drain");
        check("a5_count", valid_cnt - v0, 1);
        check("a5_data", {24'd0, Data_o}, 32'hA5);
        check("a5_lat_ok", {31'd0, (last_valid_cyc - t_start >= LAT) && (last_valid_cyc - t_start <= LAT + 2)}, 1);
        check("a5_ferr", ferr_cnt - f0, 0);

        // Back-to-back frames, no idle gap
        v0 = valid_cnt;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        drain("b2b_drain");
        check("b2b_count", valid_cnt - v0, 3);
        check("b2b_last", {24'd0, Data_o}, 32'h55);

        // False start glitch
        repeat (4) @(negedge Clk_i);
        v0 = valid_cnt; f0 = ferr_cnt;
        Rx_i = 1'b0;
        t_start = cyc + 1;
        repeat (4) @(negedge Clk_i);
        Rx_i = 1'b1;
        check("glitch_busy_hi", {31'd0, Busy_o}, 1);
        t_drop = -1;
        for (int i = 0; i < 40 && t_drop < 0; i++) begin
            @(negedge Clk_i);
            if (!Busy_o) t_drop = cyc - t_start;
        end
        check("glitch_drop_ok", {31'd0, (t_drop >= 10) && (t_drop <= 12)}, 1);
        repeat (BAUD * 2) @(negedge Clk_i);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);

        // Framing error, line held low, then recovery
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40 - BAUD) @(negedge Clk_i);
        Rx_i = 1'b1;
        repeat (BAUD) @(negedge Clk_i);
        check("fe_count", ferr_cnt - f0, 1);
        check("fe_valid", valid_cnt - v0, 0);
        check("fe_hold", {24'd0, Data_o}, 32'h55);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        drain("fe_next_drain");
        check("fe_next", {24'd0, Data_o}, 32'h12);

        // Reset mid-frame after three data bits
        Rx_i = 1'b0;
        repeat (BAUD) @(negedge Clk_i);
        Rx_i = 1'b1; repeat (BAUD) @(negedge Clk_i);
        Rx_i = 1'b0; repeat (BAUD) @(negedge Clk_i);
        Rx_i = 1'b0; repeat (BAUD) @(negedge Clk_i);
        check("mid_busy_pre", {31'd0, Busy_o}, 1);
        Reset_i = 1'b0;
        Rx_i    = 1'b1;
        #1;
        check("mid_busy", {31'd0, Busy_o}, 0);
        check("mid_data", {24'd0, Data_o}, 0);
        check("mid_valid", {31'd0, Data_valid_o}, 0);
        repeat (3) @(negedge Clk_i);
        Reset_i = 1'b1;
        repeat (BAUD) @(negedge Clk_i);
        v0 = valid_cnt;
`ifdef UART_RX_PARITY_EN
        p0 = perr_cnt;
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (BAUD) @(negedge Clk_i);
        check("par_err", perr_cnt - p0, 1);
        check("par_novalid", valid_cnt - v0, 0);
        check("par_hold", {24'd0, Data_o}, 0);
`else
        p0 = perr_cnt;
`endif
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        drain("r81_drain");
        check("r81_data", {24'd0, Data_o}, 32'h81);
        check("r81_perr", perr_cnt - p0, 0);

        repeat (4) @(negedge Clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
